// File: rtl/fec_frame_ctrl.sv
// fec_frame_ctrl: feeds a 32-bit word serially to an FEC encoder and streams the 96-bit codeword out MSB first
module fec_frame_ctrl #(
   parameter int DONE_TIMEOUT    = 64,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       word_valid_in,
   input  logic [31:0]                word_in,
   output logic                       word_ready_out,
   output logic                       fec_start_out,
   output logic                       fec_data_out,
   input  logic                       fec_done_in,
   input  logic [95:0]                fec_word_in,
   input  logic                       tx_ready_in,
   output logic                       tx_valid_out,
   output logic                       tx_bit_out,
   output logic                       tx_last_out,
   output logic                       error_out,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count_out,
   output logic [2:0]                 state_out
);
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(DONE_TIMEOUT - 1);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      SHIFT     = 3'd2,
      WAIT_DONE = 3'd3,
      SERIALIZE = 3'd4
   } state_t;
   state_t                     state_q, state_d;
   logic [31:0]                word_q, word_d;
   logic [95:0]                cw_q, cw_d;
   logic [6:0]                 cnt_q, cnt_d;
   logic [TW-1:0]              wait_q, wait_d;
   logic [FRAME_CNT_WIDTH-1:0] frames_q, frames_d;
   logic                       err_q, err_d;
   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      cw_d     = cw_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;
      frames_d = frames_q;
      err_d    = 1'b0;
      case (state_q)
         IDLE: if (word_valid_in) begin
            word_d  = word_in;
            cnt_d   = '0;
            state_d = START;
         end
         START: state_d = SHIFT;
         SHIFT: begin
            word_d = {word_q[30:0], 1'b0};
            cnt_d  = cnt_q + 7'd1;
            if (cnt_q == 7'd31) begin
               wait_d  = '0;
               state_d = WAIT_DONE;
            end
         end
         // done wins over a timeout landing in the same cycle
         WAIT_DONE: if (fec_done_in) begin
            cw_d    = fec_word_in;
            cnt_d   = '0;
            state_d = SERIALIZE;
         end else if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end else begin
            wait_d = wait_q + 1'b1;
         end
         SERIALIZE: if (tx_ready_in) begin
            cw_d  = {cw_q[94:0], 1'b0};
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'd95) begin
               frames_d = frames_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         word_q   <= '0;
         cw_q     <= '0;
         cnt_q    <= '0;
         wait_q   <= '0;
         frames_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         cw_q     <= cw_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         frames_q <= frames_d;
         err_q    <= err_d;
      end
   end
   assign word_ready_out  = state_q == IDLE;
   assign fec_start_out   = state_q == START;
   assign fec_data_out    = state_q == SHIFT && word_q[31];
   assign tx_valid_out    = state_q == SERIALIZE;
   assign tx_bit_out      = tx_valid_out && cw_q[95];
   assign tx_last_out     = tx_valid_out && cnt_q == 7'd95;
   assign error_out       = err_q;
   assign frame_count_out = frames_q;
   assign state_out       = state_q;
endmodule

// File: tb/tb_fec_frame_ctrl.sv
// tb_fec_frame_ctrl: directed frames, backpressure, timeout, mid-frame reset and 2-bit frame counter wrap
module tb_fec_frame_ctrl;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        word_valid_in = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_ready_out;
   logic        fec_start_out;
   logic        fec_data_out;
   logic        fec_done_in = 1'b0;
   logic [95:0] fec_word_in = '0;
   logic        tx_ready_in = 1'b0;
   logic        tx_valid_out;
   logic        tx_bit_out;
   logic        tx_last_out;
   logic        error_out;
   logic [1:0]  frame_count_out;
   logic [2:0]  state_out;
   int          n_vec = 0;
   int          n_bad = 0;
   fec_frame_ctrl #(.DONE_TIMEOUT(64), .FRAME_CNT_WIDTH(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .word_valid_in(word_valid_in), .word_in(word_in), .word_ready_out(word_ready_out),
      .fec_start_out(fec_start_out), .fec_data_out(fec_data_out),
      .fec_done_in(fec_done_in), .fec_word_in(fec_word_in),
      .tx_ready_in(tx_ready_in), .tx_valid_out(tx_valid_out), .tx_bit_out(tx_bit_out),
      .tx_last_out(tx_last_out), .error_out(error_out),
      .frame_count_out(frame_count_out), .state_out(state_out)
   );
   always #5 clk_in = ~clk_in;
   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic idle_outs(input string tag, input logic [1:0] cnt);
      chk({tag, "_state"}, state_out, 3'd0);
      chk({tag, "_ready"}, word_ready_out, 1'b1);
      chk({tag, "_start"}, fec_start_out, 1'b0);
      chk({tag, "_data"}, fec_data_out, 1'b0);
      chk({tag, "_txv"}, tx_valid_out, 1'b0);
      chk({tag, "_txb"}, tx_bit_out, 1'b0);
      chk({tag, "_txl"}, tx_last_out, 1'b0);
      chk({tag, "_cnt"}, frame_count_out, cnt);
   endtask
   task automatic frame(input logic [31:0] w, input logic [95:0] cw, input bit bp, input bit early,
                        input bit tmo, input int stop_bit, input logic [1:0] exp_cnt);
      int k;
      int c;
      bit ph;
      word_valid_in = 1'b1;
      word_in       = w;
      fec_done_in   = early;
      fec_word_in   = ~cw;
      tick;
      chk("start_pulse", fec_start_out, 1'b1);
      chk("start_data", fec_data_out, 1'b0);
      chk("start_state", state_out, 3'd1);
      chk("start_rdy", word_ready_out, 1'b0);
      word_in = ~w;
      for (int i = 31; i >= 0; i--) begin
         tick;
         fec_done_in = early && i > 10;
         if (i == 31) chk("start_once", fec_start_out, 1'b0);
         chk("shift_state", state_out, 3'd2);
         chk("shift_bit", fec_data_out, w[i]);
         if (i == stop_bit) begin
            word_valid_in = 1'b0;
            fec_done_in   = 1'b0;
            rst_in        = 1'b1;
            tick;
            rst_in = 1'b0;
            idle_outs("rst_mid", 2'd0);
            chk("rst_err", error_out, 1'b0);
            return;
         end
      end
      word_valid_in = 1'b0;
      fec_done_in   = !tmo;
      fec_word_in   = cw;
      tick;
      chk("wait_state", state_out, 3'd3);
      if (tmo) begin
         c = 0;
         while (state_out == 3'd3 && c < 100) begin
            c++;
            tick;
         end
         chk("tmo_len", c, 64);
         chk("tmo_err", error_out, 1'b1);
         idle_outs("tmo", exp_cnt);
         tick;
         chk("tmo_err_once", error_out, 1'b0);
         return;
      end
      tick;
      fec_done_in = 1'b0;
      chk("ser_state", state_out, 3'd4);
      k  = 95;
      c  = 0;
      ph = 1'b0;
      while (k >= 0 && c < 400) begin
         tx_ready_in = bp ? ph : 1'b1;
         chk("tx_valid", tx_valid_out, 1'b1);
         chk("tx_bit", tx_bit_out, cw[k]);
         chk("tx_last", tx_last_out, k == 0);
         tick;
         c++;
         if (tx_ready_in) k--;
         ph = !ph;
      end
      tx_ready_in = 1'b0;
      chk("ser_len", c, bp ? 192 : 96);
      idle_outs("done", exp_cnt);
      chk("done_err", error_out, 1'b0);
   endtask
   initial begin
      logic [31:0] words [5];
      words = '{32'h1357_9BDF, 32'h8000_0001, 32'h0F1E_2D3C, 32'hFFFF_FFFF, 32'h0000_0000};
      tick;
      tick;
      rst_in = 1'b0;
      idle_outs("reset", 2'd0);
      chk("reset_err", error_out, 1'b0);
      tick;
      chk("idle_hold", state_out, 3'd0);
      frame(32'hA5A5_0F0F, 96'hDEAD_BEEF_0123_4567_CAFE_BEEF, 1'b0, 1'b0, 1'b0, -1, 2'd1);
      frame(32'h3C3C_9669, 96'h0123_4567_89AB_CDEF_FEDC_BA98, 1'b1, 1'b0, 1'b0, -1, 2'd2);
      frame(32'h1234_5678, 96'h0, 1'b0, 1'b0, 1'b1, -1, 2'd2);
      frame(32'hFFFF_0000, 96'h0, 1'b0, 1'b0, 1'b0, 15, 2'd0);
      for (int i = 0; i < 5; i++)
         frame(words[i], {words[i], ~words[i], words[i] ^ 32'h5A5A_5A5A}, i[0], 1'b1, 1'b0, -1, 2'(i + 1));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fec_frame_ctrl.md
FEC_FRAME_CTRL -- requirements
Module: fec_frame_ctrl

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 64, max cycles spent in WAIT_DONE before abort.
REQ-002 SHALL have parameter FRAME_CNT_WIDTH, default 16, width of frame_count_out.
REQ-003 SHALL have port clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port word_valid_in  input  1  upstream 32-bit payload word available.
REQ-006 SHALL have port word_in  input  32  payload word.
REQ-007 SHALL have port word_ready_out  output  1  controller accepts a word this cycle.
REQ-008 SHALL have port fec_start_out  output  1  start pulse to the FEC encoder.
REQ-009 SHALL have port fec_data_out  output  1  serial payload bit to the FEC encoder.
REQ-010 SHALL have port fec_done_in  input  1  encoder done flag.
REQ-011 SHALL have port fec_word_in  input  96  encoded codeword from the encoder.
REQ-012 SHALL have port tx_ready_in  input  1  downstream accepts a bit this cycle.
REQ-013 SHALL have port tx_valid_out  output  1  tx_bit_out is valid.
REQ-014 SHALL have port tx_bit_out  output  1  serial codeword bit, MSB first.
REQ-015 SHALL have port tx_last_out  output  1  current tx bit is codeword bit 0.
REQ-016 SHALL have port error_out  output  1  one-cycle pulse on encoder timeout.
REQ-017 SHALL have port frame_count_out  output  FRAME_CNT_WIDTH  completed frames.
REQ-018 SHALL have port state_out  output  3  current state encoding.

Function
REQ-019 SHALL implement states IDLE=0, START=1, SHIFT=2, WAIT_DONE=3, SERIALIZE=4; state_out equals the encoding; codes 5-7 SHALL return to IDLE next cycle.
REQ-020 SHALL drive word_ready_out high only in IDLE; a word is accepted when word_valid_in and word_ready_out are both high, and IDLE->START.
REQ-021 SHALL hold word_valid_in/word_in ignored in all non-IDLE states; no buffering beyond the captured word.
REQ-022 SHALL assert fec_start_out for exactly one cycle, in START, with fec_data_out=0; START->SHIFT unconditionally.
REQ-023 SHALL in SHIFT present captured word bit 31 first down to bit 0, one bit per cycle for exactly 32 cycles, then SHIFT->WAIT_DONE.
REQ-024 Latency: word accepted on edge N -> fec_start_out high cycle N+1, bit 31 in cycle N+2, bit 0 in cycle N+33.
REQ-025 SHALL sample fec_done_in only in WAIT_DONE; high in SHIFT or START is ignored.
REQ-026 SHALL on fec_done_in high in WAIT_DONE capture fec_word_in into a 96-bit output register and go to SERIALIZE.
REQ-027 SHALL count WAIT_DONE cycles from 0; if count reaches DONE_TIMEOUT without done, pulse error_out one cycle, discard frame, go to IDLE, leave frame_count_out unchanged.
REQ-028 SHALL in SERIALIZE hold tx_valid_out high and tx_bit_out = current bit, starting at bit 95; advance one bit only on cycles with tx_ready_in high; hold bit while tx_ready_in low.
REQ-029 SHALL assert tx_last_out with tx_valid_out while bit 0 is presented.
REQ-030 SHALL on acceptance of bit 0 increment frame_count_out (modulo 2^FRAME_CNT_WIDTH, wraps to 0) and go to IDLE; word_ready_out high the following cycle.
REQ-031 SHALL hold tx_valid_out, tx_last_out, fec_start_out low and fec_data_out, tx_bit_out 0 outside their stated states.

Reset
REQ-032 SHALL on rst_in high at a clock edge force IDLE, word_ready_out=1 after reset release, all other outputs 0, frame_count_out=0, counters and registers cleared.
REQ-033 SHALL treat rst_in mid-frame (any state) identically: frame discarded, no error_out, no count increment; rst_in dominates all other inputs.

Verification
REQ-034 Single frame, tx_ready_in=1, word 0xA5A5_0F0F, done one cycle after bit 0 with fec_word 96'hDEAD...BEEF -> start pulse N+1, serial bits A5A50F0F MSB-first N+2..N+33, 96 tx bits equal captured codeword, tx_last on bit 0, frame_count 1.
REQ-035 Backpressure: tx_ready_in toggling 1/0 -> each bit held while ready low, 96 bits delivered in order, total SERIALIZE length 192 cycles.
REQ-036 Timeout: fec_done_in held low -> error_out pulses exactly once 64 cycles into WAIT_DONE, state IDLE, frame_count unchanged.
REQ-037 Reset mid-SHIFT at bit 15 -> next cycle state 0, all outputs 0 except word_ready_out, frame_count 0; new word then completes normally.
REQ-038 Wrap: FRAME_CNT_WIDTH=2, five frames -> frame_count sequence 1,2,3,0,1; early fec_done_in during SHIFT ignored.
